// File: rtl/back_icon_rx_port_pkg.sv
// Shared types for the icon receive path: EU addresses, receiver lists and
// the {src_addr, data} entry buffered by each receiver slot.
package back_icon_rx_port_pkg;

    localparam int unsigned EXEC_UNIT_ADDR_WIDTH = 4;
    localparam int unsigned NUM_ICON_RECEIVERS   = 8;
    localparam int unsigned ICON_DATA_WIDTH      = 32;

    typedef logic [EXEC_UNIT_ADDR_WIDTH-1:0] type_exec_unit_addr;
    typedef logic [NUM_ICON_RECEIVERS-1:0]   type_icon_receivers_list;

    typedef struct packed {
        type_exec_unit_addr          src_addr;
        logic [ICON_DATA_WIDTH-1:0]  data;
    } type_icon_rx_entry;

    localparam int unsigned ICON_RX_ENTRY_WIDTH = $bits(type_icon_rx_entry);

endpackage : back_icon_rx_port_pkg

// File: rtl/back_icon_rx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop in the same cycle frees a
// slot for a push when full. Pop while empty is ignored.
module back_icon_rx_fifo #(
    parameter int unsigned LOG2_DEPTH = 2,
    parameter int unsigned WIDTH      = 36
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LOG2_DEPTH:0]   count_o
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned PTR_W = LOG2_DEPTH + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (LOG2_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG2_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];
    assign count_o = count_q;

endmodule : back_icon_rx_fifo

// File: rtl/back_icon_rx_port.sv
// Receive end of one icon receiver slot: picks one channel addressing this
// receiver per cycle, buffers its {src_addr, data} and returns a registered ack.
module back_icon_rx_port
    import back_icon_rx_port_pkg::*;
#(
    parameter int unsigned NUM_ICON_CHANNELS = 4,
    parameter int unsigned RECEIVER_IDX      = 0,
    parameter int unsigned LOG2_BUF_DEPTH    = 2,
    parameter int unsigned DATA_WIDTH        = ICON_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  type_exec_unit_addr       ch_src_addrs_i      [NUM_ICON_CHANNELS],
    input  logic [DATA_WIDTH-1:0]    ch_data_i           [NUM_ICON_CHANNELS],
    input  type_icon_receivers_list  ch_receiver_lists_i [NUM_ICON_CHANNELS],
    output logic [NUM_ICON_CHANNELS-1:0] ch_success_o,
    output type_icon_rx_entry        operand_o,
    output logic                     operand_valid_o,
    input  logic                     operand_ready_i,
    output logic [LOG2_BUF_DEPTH:0]  buf_count_o
);

    localparam int unsigned N    = NUM_ICON_CHANNELS;
    localparam int unsigned CH_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req_c;
    logic [N-1:0]       grant_c;
    logic [2*N-1:0]     req_rot_c;
    logic               grant_valid_c;
    logic [CH_W-1:0]    grant_idx_c;
    logic [CH_W:0]      idx_sum_c;
    logic [CH_W:0]      rr_inc_c;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N-1:0]       success_q;
    logic [N-1:0]       ack_mask_q;

    logic               fifo_full, fifo_empty;
    logic               pop_c, can_accept_c;
    type_icon_rx_entry  push_entry_c;
    type_icon_rx_entry  fifo_head;
    logic               unused_list_bits;

    assign pop_c        = ~fifo_empty & operand_ready_i;
    assign can_accept_c = ~fifo_full | pop_c;

    // A channel just acked is masked for one cycle while its list is still stale.
    always_comb begin
        req_c            = '0;
        unused_list_bits = 1'b0;
        for (int ch = 0; ch < int'(N); ch++) begin
            req_c[ch]        = ch_receiver_lists_i[ch][RECEIVER_IDX] & ~ack_mask_q[ch];
            unused_list_bits = unused_list_bits ^ (^ch_receiver_lists_i[ch]);
        end
    end

    // Round-robin via double-width rotate: first set bit at or after rr_ptr.
    always_comb begin
        req_rot_c     = {req_c, req_c} >> rr_ptr_q;
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        idx_sum_c     = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!grant_valid_c && req_rot_c[i]) begin
                grant_valid_c = 1'b1;
                idx_sum_c     = (CH_W+1)'(rr_ptr_q) + (CH_W+1)'(i);
                if (idx_sum_c >= (CH_W+1)'(N)) begin
                    idx_sum_c = idx_sum_c - (CH_W+1)'(N);
                end
                grant_idx_c   = idx_sum_c[CH_W-1:0];
            end
        end
        grant_valid_c = grant_valid_c & can_accept_c;
    end

    always_comb begin
        grant_c = '0;
        if (grant_valid_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rr_inc_c = (CH_W+1)'(grant_idx_c) + (CH_W+1)'(1);
        if (rr_inc_c >= (CH_W+1)'(N)) begin
            rr_inc_c = '0;
        end
        if (grant_valid_c) begin
            rr_ptr_d = rr_inc_c[CH_W-1:0];
        end
    end

    always_comb begin
        push_entry_c          = '0;
        push_entry_c.src_addr = ch_src_addrs_i[grant_idx_c];
        push_entry_c.data     = ICON_DATA_WIDTH'(ch_data_i[grant_idx_c]);
    end

    back_icon_rx_fifo #(
        .LOG2_DEPTH (LOG2_BUF_DEPTH),
        .WIDTH      (ICON_RX_ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (grant_valid_c),
        .data_i  (push_entry_c),
        .pop_i   (pop_c),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (buf_count_o)
    );

    // Ack is registered to break any loop through the controller's success latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            success_q  <= '0;
            ack_mask_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            success_q  <= grant_c;
            ack_mask_q <= grant_c;
        end
    end

    assign ch_success_o    = success_q;
    assign operand_valid_o = ~fifo_empty;
    assign operand_o       = fifo_empty ? '0 : fifo_head;

endmodule : back_icon_rx_port
